// File: rtl/instr_loader.sv
// instr_loader: boot-time loader from a byte stream into instruction RAM.
// Builds big-endian words, checks a payload checksum, then releases the CPU.
module instr_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        WrEn,
  output logic [31:0] WrAddr,
  output logic [31:0] WrData,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] widx_q, widx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [23:0] asm_q, asm_d;
  logic [7:0]  csum_q, csum_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        cpu_hold_q, cpu_hold_d;

  logic        xfer;
  logic        restart;
  logic [15:0] len_lo;
  logic        len_bad;
  logic        last_byte;
  logic        last_word;
  logic [31:0] word;

  assign xfer      = in_valid & in_ready_q;
  assign restart   = start &
                     (state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign len_lo    = {len_q[15:8], in_data};
  assign len_bad   = (len_lo == 16'd0) ||
                     ({1'b0, len_lo} > DEPTH_W);
  assign last_byte = (bidx_q == 2'd3);
  assign last_word = (widx_q == (len_q - 16'd1));
  assign word      = {asm_q, in_data};

  assign in_ready = in_ready_q;
  assign WrEn     = wr_en_q;
  assign WrAddr   = wr_addr_q;
  assign WrData   = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign cpu_hold = cpu_hold_q;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state: frame sequencing, sticky DONE/ERROR
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) state_d = len_bad ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        if (xfer && last_byte && last_word)
          state_d = S_CHECK;
      end
      S_CHECK: begin
        if (xfer)
          state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // status outputs decoded from the next state so they register cleanly
  always_comb begin
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    cpu_hold_d = 1'b1;
    unique case (1'b1)
      (state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK}): begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      (state_d == S_DONE): begin
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      (state_d == S_ERROR): begin
        error_d = 1'b1;
      end
      default: ;
    endcase
  end

  // status output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  // datapath: length latch, word assembly, checksum, write strobe
  always_comb begin
    len_d     = len_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    asm_d     = asm_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (restart) begin
      len_d  = '0;
      widx_d = '0;
      bidx_d = '0;
      asm_d  = '0;
      csum_d = '0;
    end else if (xfer) begin
      case (state_q)
        S_LEN_HI: len_d = {in_data, len_q[7:0]};
        S_LEN_LO: len_d = len_lo;
        S_DATA: begin
          asm_d  = {asm_q[15:0], in_data};
          csum_d = csum_q + in_data;
          bidx_d = bidx_q + 2'd1;
          if (last_byte) begin
            wr_en_d   = 1'b1;
            wr_data_d = word;
            wr_addr_d = ADDR_BASE + {14'd0, widx_q, 2'b00};
            widx_d    = widx_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // datapath registers; RAM contents are never rolled back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q     <= '0;
      widx_q    <= '0;
      bidx_q    <= '0;
      asm_q     <= '0;
      csum_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      len_q     <= len_d;
      widx_q    <= widx_d;
      bidx_q    <= bidx_d;
      asm_q     <= asm_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table vectors, hand sequences and random frames
// checked against a frame-level reference model.
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        WrEn;
  logic [31:0] WrAddr;
  logic [31:0] WrData;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int checks = 0;
  int failures = 0;

  logic [63:0] got_wr[$];
  logic [63:0] exp_wr[$];
  logic [7:0]  frame_q[$];
  bit          exp_done;
  bit          exp_err;
  logic        wr_prev = 1'b0;

  typedef struct {
    logic [127:0] fr;
    int           n;
    bit           done;
    bit           err;
    int           nwr;
    logic [31:0]  la;
    logic [31:0]  ld;
  } vec_t;

  vec_t vt[5];

  always #5 clk = ~clk;

  instr_loader #(.DEPTH(256), .ADDR_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData),
    .busy(busy), .done(done), .error(error),
    .cpu_hold(cpu_hold)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // capture every write; a strobe must never last two cycles
  always @(negedge clk) begin
    if (WrEn) begin
      got_wr.push_back({WrAddr, WrData});
      chk("wren_one_cycle", 32'(wr_prev), 32'd0);
    end
    wr_prev <= WrEn;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // reference model: decode the whole frame with plain arithmetic
  task automatic model;
    int n;
    logic [7:0] s;
    logic [31:0] w32;
    exp_wr.delete();
    n = {frame_q[0], frame_q[1]};
    if (n == 0 || n > 256) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
    end else begin
      s = 8'h00;
      for (int w = 0; w < n; w++) begin
        w32 = 32'h0;
        for (int k = 0; k < 4; k++) begin
          w32 = (w32 << 8) | 32'(frame_q[2 + 4*w + k]);
          s   = s + frame_q[2 + 4*w + k];
        end
        exp_wr.push_back({BASE + 32'(w*4), w32});
      end
      exp_done = (frame_q[2 + 4*n] == s);
      exp_err  = !exp_done;
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ready_after_start", 32'(in_ready), 32'd1);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("hold_while_busy", 32'(cpu_hold), 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    int w = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got in_ready=0 want 1");
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic run_frame(input int max_gap, input bit mid_start);
    got_wr.delete();
    model();
    pulse_start();
    for (int i = 0; i < frame_q.size(); i++) begin
      if (max_gap > 0)
        repeat ($urandom_range(max_gap, 0)) tick();
      if (mid_start && i == 5) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (i == frame_q.size() - 1)
        chk("busy_before_last", 32'(busy), 32'd1);
      send(frame_q[i]);
    end
    chk("done", 32'(done), 32'(exp_done));
    chk("error", 32'(error), 32'(exp_err));
    chk("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
    chk("ready_low_after", 32'(in_ready), 32'd0);
    chk("busy_low_after", 32'(busy), 32'd0);
    tick();
    chk("n_writes", 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
      chk("wr_addr", got_wr[i][63:32], exp_wr[i][63:32]);
      chk("wr_data", got_wr[i][31:0], exp_wr[i][31:0]);
    end
  endtask

  task automatic load_vec(input int k);
    frame_q.delete();
    for (int i = 0; i < vt[k].n; i++)
      frame_q.push_back(vt[k].fr[8*(vt[k].n-1-i) +: 8]);
  endtask

  task automatic check_reset_vals;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wren", 32'(WrEn), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_wraddr", WrAddr, 32'd0);
    chk("rst_wrdata", WrData, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] s;
    logic [7:0] b;

    vt[0] = '{128'h0002080000030800002E41, 11, 1'b1, 1'b0, 2,
              32'h4, 32'h0800002E};
    vt[1] = '{128'h0000, 2, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vt[2] = '{128'h0101, 2, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vt[3] = '{128'h0002080000030800002E44, 11, 1'b0, 1'b1, 2,
              32'h4, 32'h0800002E};
    vt[4] = '{128'h0001201C00003C, 7, 1'b1, 1'b0, 1,
              32'h0, 32'h201C0000};

    tick();
    tick();
    check_reset_vals();
    reset = 1'b1;
    tick();

    // table vectors, one byte per cycle
    for (int k = 0; k < 5; k++) begin
      load_vec(k);
      run_frame(0, 1'b0);
      chk("tbl_done", 32'(done), 32'(vt[k].done));
      chk("tbl_error", 32'(error), 32'(vt[k].err));
      chk("tbl_nwr", 32'(got_wr.size()), 32'(vt[k].nwr));
      if (vt[k].nwr > 0 && got_wr.size() > 0) begin
        chk("tbl_last_addr", got_wr[$][63:32], vt[k].la);
        chk("tbl_last_data", got_wr[$][31:0], vt[k].ld);
      end
    end

    // backpressure gaps plus an ignored mid-frame start
    load_vec(0);
    run_frame(5, 1'b1);

    // reset mid-load right after the first word is strobed
    load_vec(0);
    pulse_start();
    for (int i = 0; i < 6; i++) send(frame_q[i]);
    chk("mid_wren", 32'(WrEn), 32'd1);
    chk("mid_wrdata", WrData, 32'h08000003);
    #1 reset = 1'b0;
    #1 check_reset_vals();
    tick();
    reset = 1'b1;
    tick();
    run_frame(0, 1'b0);
    chk("after_rst_done", 32'(done), 32'd1);

    // restart after DONE with a single-word image
    load_vec(4);
    run_frame(2, 1'b0);
    chk("restart_done", 32'(done), 32'd1);

    // random frames against the model
    for (int it = 0; it < 15; it++) begin
      frame_q.delete();
      if ($urandom_range(5, 0) == 0) begin
        n = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(65535, 257);
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
      end else begin
        n = $urandom_range(5, 1);
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
        s = 8'h00;
        for (int i = 0; i < 4*n; i++) begin
          b = 8'($urandom);
          frame_q.push_back(b);
          s = s + b;
        end
        if ($urandom_range(3, 0) == 0)
          s = s + 8'($urandom_range(255, 1));
        frame_q.push_back(s);
      end
      run_frame(5, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
